// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter and the commit logic that consumes
// its completion stream.
package wb_arbiter_pkg;

  localparam int c_xlen           = 32;
  localparam int c_arch_addr_bits = 5;
  localparam int c_seq_num_bits   = 5;
  localparam int c_phys_addr_bits = 6;

  // One X->W message as it travels from an execute unit to commit.
  typedef struct packed {
    logic [c_xlen-1:0]           pc;
    logic [c_seq_num_bits-1:0]   seq_num;
    logic [c_arch_addr_bits-1:0] waddr;
    logic [c_xlen-1:0]           wdata;
    logic                        wen;
    logic [c_phys_addr_bits-1:0] preg;
    logic [c_phys_addr_bits-1:0] ppreg;
  } wb_msg_t;

  // True when completing this message must update the physical register
  // file. Architectural x0 is hard-wired to zero, so it is never written.
  function automatic logic writes_rf(input wb_msg_t m);
    return m.wen && (m.waddr != '0);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// X->W stream between one execute unit (producer, X_intf) and the writeback
// arbiter (consumer, W_intf).
//
// Handshake: the producer raises val with a stable message; the consumer
// drives rdy; a transfer happens in a cycle where val and rdy are both 1.
// rdy may depend combinationally on val; val must not depend on rdy.
interface X__WIntf #(
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
);
  logic                        val;
  logic                        rdy;
  logic [31:0]                 pc;
  logic [p_seq_num_bits-1:0]   seq_num;
  logic [4:0]                  waddr;
  logic [31:0]                 wdata;
  logic                        wen;
  logic [p_phys_addr_bits-1:0] preg;
  logic [p_phys_addr_bits-1:0] ppreg;

  modport X_intf (
    output val, pc, seq_num, waddr, wdata, wen, preg, ppreg,
    input  rdy
  );

  modport W_intf (
    input  val, pc, seq_num, waddr, wdata, wen, preg, ppreg,
    output rdy
  );
endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (wrapping modulo p_width). The pointer moves to just past the
// winner only when en is high and a grant is issued; otherwise it holds.
module rr_arbiter #(
  parameter int p_width = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] req,
  input  logic               en,
  output logic [p_width-1:0] gnt
);

  localparam int c_ptr_bits = (p_width > 1) ? $clog2(p_width) : 1;
  localparam logic [c_ptr_bits:0] c_width = (c_ptr_bits+1)'(p_width);
  localparam logic [c_ptr_bits:0] c_last  = (c_ptr_bits+1)'(p_width - 1);

  logic [c_ptr_bits-1:0] ptr;
  logic [c_ptr_bits-1:0] ptr_next;
  logic [c_ptr_bits:0]   idx;
  logic                  found;

  // Scan requesters starting at ptr; p_width need not be a power of two, so
  // the wrap is an explicit subtract rather than a bit truncation.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    ptr_next = ptr;
    idx      = '0;
    for (int off = 0; off < p_width; off++) begin
      idx = {1'b0, ptr} + (c_ptr_bits+1)'(off);
      if (idx >= c_width) idx = idx - c_width;
      if (en && !found && req[idx[c_ptr_bits-1:0]]) begin
        gnt[idx[c_ptr_bits-1:0]] = 1'b1;
        found    = 1'b1;
        ptr_next = (idx == c_last) ? '0 : idx[c_ptr_bits-1:0] + c_ptr_bits'(1);
      end
    end
  end

  // Advance the pointer past the winner; reset returns it to input 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges p_num_pipes execute-unit X->W streams into one
// registered completion stream plus the physical register-file write port.
// Round-robin fair, at most one grant per cycle, full back-pressure from the
// completion consumer.
//
// Build option: define WB_ARBITER_BYPASS_EN to let a granted input flow
// straight to cmpl_*/rf_* in the same cycle when the entry is empty and
// cmpl_rdy is high. Without it the path is always one registered stage.
//
// Completion handshake: cmpl_val/message are held stable until a cycle with
// cmpl_rdy high; that cycle is the completion and also the RF write.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int p_num_pipes      = 4,
  parameter int p_seq_num_bits   = c_seq_num_bits,
  parameter int p_phys_addr_bits = c_phys_addr_bits
) (
  input  logic                        clk,
  input  logic                        rst,
  X__WIntf.W_intf                     Ex [p_num_pipes],
  output logic                        cmpl_val,
  input  logic                        cmpl_rdy,
  output logic [31:0]                 cmpl_pc,
  output logic [p_seq_num_bits-1:0]   cmpl_seq_num,
  output logic [4:0]                  cmpl_waddr,
  output logic [p_phys_addr_bits-1:0] cmpl_preg,
  output logic [p_phys_addr_bits-1:0] cmpl_ppreg,
  output logic                        cmpl_wen,
  output logic                        rf_wen,
  output logic [p_phys_addr_bits-1:0] rf_waddr,
  output logic [31:0]                 rf_wdata
);

  logic [p_num_pipes-1:0] req;
  logic [p_num_pipes-1:0] gnt;
  wb_msg_t                in_msg [p_num_pipes];
  wb_msg_t                sel_msg;
  wb_msg_t                entry_msg;
  wb_msg_t                out_msg;
  logic                   entry_val;
  logic                   out_val;
  logic                   slot_free;
  logic                   bypass;
  logic                   load;

  // Flatten the interface array into plain vectors; rdy is the grant.
  for (genvar gi = 0; gi < p_num_pipes; gi++) begin : g_in
    assign req[gi]    = Ex[gi].val;
    assign Ex[gi].rdy = gnt[gi];
    assign in_msg[gi] = '{
      pc:      Ex[gi].pc,
      seq_num: c_seq_num_bits'(Ex[gi].seq_num),
      waddr:   Ex[gi].waddr,
      wdata:   Ex[gi].wdata,
      wen:     Ex[gi].wen,
      preg:    c_phys_addr_bits'(Ex[gi].preg),
      ppreg:   c_phys_addr_bits'(Ex[gi].ppreg)
    };
  end

  // The slot can take a new message when it is empty or is draining now.
  // Written with cmpl_rdy directly (not cmpl_val & cmpl_rdy) so the bypass
  // build has no loop through cmpl_val back into the grant.
  assign slot_free = !entry_val || cmpl_rdy;

  rr_arbiter #(
    .p_width (p_num_pipes)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (slot_free),
    .gnt (gnt)
  );

  // One-hot grant selects the winning message.
  always_comb begin
    sel_msg = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      if (gnt[i]) sel_msg = in_msg[i];
    end
  end

`ifdef WB_ARBITER_BYPASS_EN
  assign bypass = !entry_val && cmpl_rdy && (|gnt);
`else
  assign bypass = 1'b0;
`endif

  // A granted message is registered unless it is bypassed this cycle.
  assign load = (|gnt) && !bypass;

  // Output entry: refill wins over drain, so drain+refill keeps val high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_val <= 1'b0;
      entry_msg <= '0;
    end else if (load) begin
      entry_val <= 1'b1;
      entry_msg <= sel_msg;
    end else if (entry_val && cmpl_rdy) begin
      entry_val <= 1'b0;
    end
  end

  // Present the held entry, zeroed while invalid; a bypass overrides it.
  always_comb begin
    out_val = entry_val;
    out_msg = entry_val ? entry_msg : '0;
    if (bypass) begin
      out_val = 1'b1;
      out_msg = sel_msg;
    end
  end

  assign cmpl_val     = out_val;
  assign cmpl_pc      = out_msg.pc;
  assign cmpl_seq_num = p_seq_num_bits'(out_msg.seq_num);
  assign cmpl_waddr   = out_msg.waddr;
  assign cmpl_preg    = p_phys_addr_bits'(out_msg.preg);
  assign cmpl_ppreg   = p_phys_addr_bits'(out_msg.ppreg);
  assign cmpl_wen     = out_msg.wen;

  // RF write happens exactly in the completion cycle; stores and x0 skip it.
  assign rf_wen   = out_val && cmpl_rdy && writes_rf(out_msg);
  assign rf_waddr = p_phys_addr_bits'(out_msg.preg);
  assign rf_wdata = out_msg.wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed sequences, a vector table for the 4-input
// round-robin and back-pressure behaviour, a 3-input instance for pointer
// wrap, and randomized traffic against a transaction-level model.
module tb_wb_arbiter;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  seq_num;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [5:0]  preg;
    logic [5:0]  ppreg;
  } tb_msg_t;

  typedef struct {
    logic [3:0] val;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_cval;
    logic [4:0] exp_seq;
    logic       exp_rf_wen;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 4-input instance ----------------
  logic [3:0]  val4 = '0;
  logic [3:0]  rdy4;
  logic        cmpl_rdy4 = 1'b0;
  tb_msg_t     msg4 [4];
  logic        c4_val, c4_wen, rf4_wen;
  logic [31:0] c4_pc, rf4_wdata;
  logic [4:0]  c4_seq, c4_waddr;
  logic [5:0]  c4_preg, c4_ppreg, rf4_waddr;

  X__WIntf #(.p_seq_num_bits(5), .p_phys_addr_bits(6)) ex4 [4] ();

  for (genvar gi = 0; gi < 4; gi++) begin : g_ex4
    assign ex4[gi].val     = val4[gi];
    assign ex4[gi].pc      = msg4[gi].pc;
    assign ex4[gi].seq_num = msg4[gi].seq_num;
    assign ex4[gi].waddr   = msg4[gi].waddr;
    assign ex4[gi].wdata   = msg4[gi].wdata;
    assign ex4[gi].wen     = msg4[gi].wen;
    assign ex4[gi].preg    = msg4[gi].preg;
    assign ex4[gi].ppreg   = msg4[gi].ppreg;
    assign rdy4[gi]        = ex4[gi].rdy;
  end

  wb_arbiter #(.p_num_pipes(4), .p_seq_num_bits(5), .p_phys_addr_bits(6)) dut4 (
    .clk(clk), .rst(rst_n), .Ex(ex4),
    .cmpl_val(c4_val), .cmpl_rdy(cmpl_rdy4), .cmpl_pc(c4_pc),
    .cmpl_seq_num(c4_seq), .cmpl_waddr(c4_waddr), .cmpl_preg(c4_preg),
    .cmpl_ppreg(c4_ppreg), .cmpl_wen(c4_wen), .rf_wen(rf4_wen),
    .rf_waddr(rf4_waddr), .rf_wdata(rf4_wdata)
  );

  // ---------------- 3-input instance ----------------
  logic [2:0]  val3 = '0;
  logic [2:0]  rdy3;
  logic        cmpl_rdy3 = 1'b0;
  tb_msg_t     msg3 [3];
  logic        c3_val, c3_wen, rf3_wen;
  logic [31:0] c3_pc, rf3_wdata;
  logic [4:0]  c3_seq, c3_waddr;
  logic [5:0]  c3_preg, c3_ppreg, rf3_waddr;

  X__WIntf #(.p_seq_num_bits(5), .p_phys_addr_bits(6)) ex3 [3] ();

  for (genvar gi = 0; gi < 3; gi++) begin : g_ex3
    assign ex3[gi].val     = val3[gi];
    assign ex3[gi].pc      = msg3[gi].pc;
    assign ex3[gi].seq_num = msg3[gi].seq_num;
    assign ex3[gi].waddr   = msg3[gi].waddr;
    assign ex3[gi].wdata   = msg3[gi].wdata;
    assign ex3[gi].wen     = msg3[gi].wen;
    assign ex3[gi].preg    = msg3[gi].preg;
    assign ex3[gi].ppreg   = msg3[gi].ppreg;
    assign rdy3[gi]        = ex3[gi].rdy;
  end

  wb_arbiter #(.p_num_pipes(3), .p_seq_num_bits(5), .p_phys_addr_bits(6)) dut3 (
    .clk(clk), .rst(rst_n), .Ex(ex3),
    .cmpl_val(c3_val), .cmpl_rdy(cmpl_rdy3), .cmpl_pc(c3_pc),
    .cmpl_seq_num(c3_seq), .cmpl_waddr(c3_waddr), .cmpl_preg(c3_preg),
    .cmpl_ppreg(c3_ppreg), .cmpl_wen(c3_wen), .rf_wen(rf3_wen),
    .rf_waddr(rf3_waddr), .rf_wdata(rf3_wdata)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [86:0] exp_q [$];
  int          m_ptr;
  vec_t        vecs [15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic tb_msg_t mk_msg(input int i);
    tb_msg_t m;
    m.pc      = 32'h1000 + 32'(i * 4);
    m.seq_num = 5'(8 + i);
    m.waddr   = 5'(i + 1);
    m.wdata   = 32'hA000_0000 + 32'(i);
    m.wen     = 1'b1;
    m.preg    = 6'(16 + i);
    m.ppreg   = 6'(32 + i);
    return m;
  endfunction

  function automatic tb_msg_t out4();
    tb_msg_t m;
    m.pc      = c4_pc;
    m.seq_num = c4_seq;
    m.waddr   = c4_waddr;
    m.wdata   = rf4_wdata;
    m.wen     = c4_wen;
    m.preg    = c4_preg;
    m.ppreg   = c4_ppreg;
    return m;
  endfunction

  // First valid input at or after p, wrapping over 4 inputs; -1 if none.
  function automatic int first_from(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    val4 = '0; val3 = '0;
    cmpl_rdy4 = 1'b0; cmpl_rdy3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step4(input logic [3:0] v, input logic r);
    @(negedge clk);
    val4 = v; cmpl_rdy4 = r;
    #1;
  endtask

  task automatic step3(input logic [2:0] v, input logic r);
    @(negedge clk);
    val3 = v; cmpl_rdy3 = r;
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 4; i++) msg4[i] = mk_msg(i);
    for (int i = 0; i < 3; i++) msg3[i] = mk_msg(i);

    // Reset state
    do_reset();
    step4(4'b0000, 1'b0);
    check("rst_cmpl_val", c4_val, 1'b0);
    check("rst_rf_wen", rf4_wen, 1'b0);
    check("rst_msg_zero", out4(), '0);
    check("rst_rdy", rdy4, 4'b0000);

    // Single input on Ex[2], one-cycle latency into RF write
    msg4[2] = '{pc: 32'h400, seq_num: 5'd3, waddr: 5'd5, wdata: 32'hDEADBEEF,
                wen: 1'b1, preg: 6'd12, ppreg: 6'd7};
    step4(4'b0100, 1'b1);
    check("single_rdy", rdy4, 4'b0100);
    check("single_not_yet", c4_val, 1'b0);
    step4(4'b0000, 1'b1);
    check("single_cmpl_val", c4_val, 1'b1);
    check("single_seq", c4_seq, 5'd3);
    check("single_waddr", c4_waddr, 5'd5);
    check("single_rf_wen", rf4_wen, 1'b1);
    check("single_rf_waddr", rf4_waddr, 6'd12);
    check("single_rf_wdata", rf4_wdata, 32'hDEADBEEF);
    step4(4'b0000, 1'b1);
    check("single_drained", c4_val, 1'b0);

    // x0 destination and a store: both complete, neither writes the RF
    msg4[0] = '{pc: 32'h500, seq_num: 5'd1, waddr: 5'd0, wdata: 32'h1111,
                wen: 1'b1, preg: 6'd20, ppreg: 6'd21};
    msg4[1] = '{pc: 32'h504, seq_num: 5'd2, waddr: 5'd7, wdata: 32'h2222,
                wen: 1'b0, preg: 6'd22, ppreg: 6'd23};
    step4(4'b0001, 1'b1);
    check("x0_rdy", rdy4, 4'b0001);
    step4(4'b0010, 1'b1);
    check("x0_cmpl_val", c4_val, 1'b1);
    check("x0_seq", c4_seq, 5'd1);
    check("x0_rf_wen", rf4_wen, 1'b0);
    check("store_rdy", rdy4, 4'b0010);
    step4(4'b0000, 1'b1);
    check("store_cmpl_val", c4_val, 1'b1);
    check("store_seq", c4_seq, 5'd2);
    check("store_cmpl_wen", c4_wen, 1'b0);
    check("store_rf_wen", rf4_wen, 1'b0);

    // Vector table: round-robin, back-pressure, drain+refill, pointer hold
    for (int i = 0; i < 4; i++) msg4[i] = mk_msg(i);
    vecs[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, 5'd0,  1'b0};
    vecs[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 5'd8,  1'b1};
    vecs[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 5'd9,  1'b1};
    vecs[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 5'd10, 1'b1};
    vecs[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 5'd11, 1'b1};
    vecs[5]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 5'd8,  1'b0};
    vecs[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 5'd8,  1'b0};
    vecs[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 5'd8,  1'b0};
    vecs[8]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 5'd8,  1'b1};
    vecs[9]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 5'd9,  1'b1};
    vecs[10] = '{4'h0, 1'b1, 4'b0000, 1'b0, 5'd0,  1'b0};
    vecs[11] = '{4'h4, 1'b0, 4'b0100, 1'b0, 5'd0,  1'b0};
    vecs[12] = '{4'h0, 1'b1, 4'b0000, 1'b1, 5'd10, 1'b1};
    vecs[13] = '{4'hA, 1'b1, 4'b1000, 1'b0, 5'd0,  1'b0};
    vecs[14] = '{4'hA, 1'b1, 4'b0010, 1'b1, 5'd11, 1'b1};
    do_reset();
    for (int v = 0; v < 15; v++) begin
      step4(vecs[v].val, vecs[v].rdy);
      check($sformatf("vec%0d_rdy", v), rdy4, vecs[v].exp_rdy);
      check($sformatf("vec%0d_cmpl_val", v), c4_val, vecs[v].exp_cval);
      check($sformatf("vec%0d_seq", v), c4_seq, vecs[v].exp_seq);
      check($sformatf("vec%0d_preg", v), c4_preg,
            vecs[v].exp_cval ? 6'(vecs[v].exp_seq + 5'd8) : 6'd0);
      check($sformatf("vec%0d_rf_wen", v), rf4_wen, vecs[v].exp_rf_wen);
    end

    // Asynchronous reset while an entry is held under back-pressure
    step4(4'b0000, 1'b1);
    check("arst_pre_drain", c4_seq, 5'd9);
    step4(4'b0010, 1'b0);
    check("arst_load_rdy", rdy4, 4'b0010);
    step4(4'b0000, 1'b0);
    check("arst_held", c4_val, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_val_drop", c4_val, 1'b0);
    check("arst_msg_zero", c4_seq, 5'd0);
    check("arst_rf_wen", rf4_wen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step4(4'hF, 1'b1);
    check("arst_first_grant", rdy4, 4'b0001);
    step4(4'h0, 1'b1);
    check("arst_first_cmpl", c4_seq, 5'd8);

    // Three inputs: grant to Ex[2] wraps the pointer to 0
    do_reset();
    step3(3'b010, 1'b1);
    check("p3_grant1", rdy3, 3'b010);
    step3(3'b110, 1'b1);
    check("p3_grant2", rdy3, 3'b100);
    check("p3_cmpl1", c3_seq, 5'd9);
    step3(3'b011, 1'b1);
    check("p3_wrap_grant0", rdy3, 3'b001);
    check("p3_cmpl2", c3_seq, 5'd10);
    step3(3'b000, 1'b1);
    check("p3_cmpl0", c3_seq, 5'd8);
    check("p3_cmpl0_val", c3_val, 1'b1);

    // Randomized traffic against a transaction-level model: exp_q holds
    // messages accepted but not yet completed, m_ptr the next-preferred input.
    do_reset();
    m_ptr = 0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      logic       exp_cval;
      tb_msg_t    exp_m;
      int         g;
      logic [3:0] exp_rdy;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        msg4[i].pc      = $urandom;
        msg4[i].seq_num = 5'($urandom);
        msg4[i].waddr   = 5'($urandom_range(0, 31));
        msg4[i].wdata   = $urandom;
        msg4[i].wen     = 1'($urandom_range(0, 1));
        msg4[i].preg    = 6'($urandom);
        msg4[i].ppreg   = 6'($urandom);
      end
      val4      = 4'($urandom_range(0, 15));
      cmpl_rdy4 = ($urandom_range(0, 3) != 0);
      #1;
      exp_cval = (exp_q.size() != 0);
      exp_m    = exp_cval ? tb_msg_t'(exp_q[0]) : '0;
      check("rnd_cmpl_val", c4_val, exp_cval);
      check("rnd_msg", out4(), exp_m);
      check("rnd_rf_wen", rf4_wen,
            exp_cval && cmpl_rdy4 && exp_m.wen && (exp_m.waddr != 5'd0));
      check("rnd_rf_waddr", rf4_waddr, exp_m.preg);
      g = (!exp_cval || cmpl_rdy4) ? first_from(val4, m_ptr) : -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      check("rnd_rdy", rdy4, exp_rdy);
      if (exp_cval && cmpl_rdy4) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(msg4[g]);
        m_ptr = (g + 1) % 4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
